// File: rtl/alu_operand_loader.sv
// ---------------------------------------------------------------------------
// alu_operand_loader
//
// Sequential front end of the Lab 3 ALU. Successive load pulses capture
// operand A, operand B and the opcode from the board switches. Each value is
// then held as a stable registered input to the combinational ALU. One cycle
// after the opcode is captured, the ALU result and carry are registered. The
// Z/N/C status flags for the display stage are derived from that register.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   load       - single-cycle press pulse (debounced/edge-detected upstream)
//   clear      - synchronous abort back to LOAD_A, priority over load
//   sw_data    - switch value captured as operand A or B
//   sw_op      - switch value captured as the opcode
//   alu_result - combinational ALU output
//   alu_cout   - ALU carry/borrow out
//   op_a       - registered operand A
//   op_b       - registered operand B
//   alu_op     - registered opcode
//   result_q   - registered ALU result
//   flag_z     - result_q is zero
//   flag_n     - result_q sign bit
//   flag_c     - registered carry/borrow
//   done       - one-cycle pulse on the cycle result_q has just updated
//   state_o    - current state encoding for the LEDs
// ---------------------------------------------------------------------------
module alu_operand_loader #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [N-1:0] sw_data,
    input  logic [3:0]   sw_op,
    input  logic [N-1:0] alu_result,
    input  logic         alu_cout,
    output logic [N-1:0] op_a,
    output logic [N-1:0] op_b,
    output logic [3:0]   alu_op,
    output logic [N-1:0] result_q,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_c,
    output logic         done,
    output logic [2:0]   state_o
);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    // State register. Reset returns the sequence to the first operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_A;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. clear wins over everything else. EXEC always
    // advances after one cycle regardless of load. A load from SHOW counts
    // as the first press of the next operation, so it jumps to LOAD_B.
    // Unused encodings fall back to LOAD_A.
    always_comb begin
        next_state = LOAD_A;
        if (!clear) begin
            case (state)
                LOAD_A:  next_state = load ? LOAD_B  : LOAD_A;
                LOAD_B:  next_state = load ? LOAD_OP : LOAD_B;
                LOAD_OP: next_state = load ? EXEC    : LOAD_OP;
                EXEC:    next_state = SHOW;
                SHOW:    next_state = load ? LOAD_B  : SHOW;
                default: next_state = LOAD_A;
            endcase
        end
    end

    // Datapath registers. Each capture is qualified by the current state.
    // The result and carry are taken at the closing edge of EXEC, and done is
    // raised on that same edge so it marks the first SHOW cycle only.
    // clear zeroes everything, which also cancels an in-flight EXEC capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            alu_op   <= '0;
            result_q <= '0;
            flag_c   <= 1'b0;
            done     <= 1'b0;
        end else if (clear) begin
            op_a     <= '0;
            op_b     <= '0;
            alu_op   <= '0;
            result_q <= '0;
            flag_c   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                LOAD_A, SHOW: begin
                    if (load) begin
                        op_a <= sw_data;
                    end
                end
                LOAD_B: begin
                    if (load) begin
                        op_b <= sw_data;
                    end
                end
                LOAD_OP: begin
                    if (load) begin
                        alu_op <= sw_op;
                    end
                end
                EXEC: begin
                    result_q <= alu_result;
                    flag_c   <= alu_cout;
                    done     <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Z and N follow result_q directly, so they move on the same edge.
    assign flag_z  = (result_q == '0);
    assign flag_n  = result_q[N-1];
    assign state_o = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_loader
//
// Directed bench for alu_operand_loader with N = 6. A small ALU model drives
// alu_result/alu_cout from the registered operands (opcode 0 = ADD,
// 4 = XOR, anything else = AND). Inputs change on the falling edge, and
// outputs are sampled on the falling edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_alu_operand_loader;

    localparam int N = 6;

    logic         clk;
    logic         rst_n;
    logic         load;
    logic         clear;
    logic [N-1:0] sw_data;
    logic [3:0]   sw_op;
    logic [N-1:0] alu_result;
    logic         alu_cout;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [3:0]   alu_op;
    logic [N-1:0] result_q;
    logic         flag_z;
    logic         flag_n;
    logic         flag_c;
    logic         done;
    logic [2:0]   state_o;

    int total = 0;
    int bad   = 0;

    alu_operand_loader #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .clear      (clear),
        .sw_data    (sw_data),
        .sw_op      (sw_op),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_op     (alu_op),
        .result_q   (result_q),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_c     (flag_c),
        .done       (done),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU stand-in fed by the registered operands
    always_comb begin
        alu_result = '0;
        alu_cout   = 1'b0;
        case (alu_op)
            4'h0:    {alu_cout, alu_result} = {1'b0, op_a} + {1'b0, op_b};
            4'h4:    alu_result = op_a ^ op_b;
            default: alu_result = op_a & op_b;
        endcase
    end

    // One press: entered on a falling edge, returns on the next falling edge
    task automatic pulse_load(input logic [N-1:0] d, input logic [3:0] o);
        sw_data = d;
        sw_op   = o;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; clear = 1'b0; sw_data = '0; sw_op = '0;
        #7;
        total++; if (state_o !== 3'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d want 0", state_o); end
        total++; if ({op_a, op_b, alu_op, result_q} !== '0) begin bad++; $display("[TB] FAIL reset_regs: got %h %h %h %h want 0", op_a, op_b, alu_op, result_q); end
        total++; if ({flag_z, flag_n, flag_c, done} !== 4'b1000) begin bad++; $display("[TB] FAIL reset_flags: got %b want 1000", {flag_z, flag_n, flag_c, done}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (state_o !== 3'd0 || done !== 1'b0 || flag_z !== 1'b1) begin bad++; $display("[TB] FAIL post_reset: state %0d done %b z %b want 0 0 1", state_o, done, flag_z); end
    endtask

    task automatic test_xor();
        pulse_load(6'b101100, 4'h0);
        total++; if (state_o !== 3'd1 || op_a !== 6'b101100) begin bad++; $display("[TB] FAIL load_a: state %0d op_a %b want 1 101100", state_o, op_a); end
        pulse_load(6'b011010, 4'h0);
        total++; if (state_o !== 3'd2 || op_b !== 6'b011010) begin bad++; $display("[TB] FAIL load_b: state %0d op_b %b want 2 011010", state_o, op_b); end
        pulse_load(6'b000000, 4'h4);
        total++; if (state_o !== 3'd3 || alu_op !== 4'h4 || result_q !== 6'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL exec_entry: state %0d op %h res %b done %b want 3 4 000000 0", state_o, alu_op, result_q, done); end
        @(negedge clk);
        total++; if (result_q !== 6'b110110) begin bad++; $display("[TB] FAIL xor_result: got %b want 110110", result_q); end
        total++; if ({flag_n, flag_z, flag_c, done} !== 4'b1001 || state_o !== 3'd4) begin bad++; $display("[TB] FAIL xor_flags: nzcd %b state %0d want 1001 4", {flag_n, flag_z, flag_c, done}, state_o); end
        @(negedge clk);
        total++; if (done !== 1'b0 || state_o !== 3'd4 || result_q !== 6'b110110) begin bad++; $display("[TB] FAIL show_hold: done %b state %0d res %b want 0 4 110110", done, state_o, result_q); end
    endtask

    task automatic test_zero();
        pulse_load(6'b010101, 4'h0);
        pulse_load(6'b010101, 4'h0);
        pulse_load(6'b000000, 4'h4);
        @(negedge clk);
        total++; if (result_q !== 6'b0 || flag_z !== 1'b1 || flag_n !== 1'b0 || done !== 1'b1) begin bad++; $display("[TB] FAIL zero_result: res %b z %b n %b done %b want 000000 1 0 1", result_q, flag_z, flag_n, done); end
    endtask

    task automatic test_load_in_exec();
        pulse_load(6'b000011, 4'h0);
        pulse_load(6'b000101, 4'h0);
        pulse_load(6'b000000, 4'h0);
        pulse_load(6'b111111, 4'h4);
        total++; if (state_o !== 3'd4 || op_a !== 6'b000011 || op_b !== 6'b000101 || alu_op !== 4'h0) begin bad++; $display("[TB] FAIL exec_load_ignored: state %0d a %b b %b op %h want 4 000011 000101 0", state_o, op_a, op_b, alu_op); end
        total++; if (result_q !== 6'b001000 || done !== 1'b1) begin bad++; $display("[TB] FAIL exec_add: res %b done %b want 001000 1", result_q, done); end
    endtask

    task automatic test_clear_load_op();
        pulse_load(6'b100001, 4'h0);
        pulse_load(6'b000110, 4'h0);
        total++; if (state_o !== 3'd2) begin bad++; $display("[TB] FAIL reach_load_op: got %0d want 2", state_o); end
        clear = 1'b1; load = 1'b1; sw_op = 4'hF;
        @(negedge clk);
        clear = 1'b0; load = 1'b0;
        total++; if (state_o !== 3'd0 || alu_op !== 4'h0) begin bad++; $display("[TB] FAIL clear_priority: state %0d op %h want 0 0", state_o, alu_op); end
        total++; if ({op_a, op_b, result_q} !== '0 || flag_z !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL clear_regs: a %b b %b res %b z %b done %b want zeros z=1", op_a, op_b, result_q, flag_z, done); end
    endtask

    task automatic test_clear_exec();
        pulse_load(6'b000001, 4'h0);
        pulse_load(6'b000001, 4'h0);
        pulse_load(6'b000000, 4'h0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        total++; if (state_o !== 3'd0 || result_q !== 6'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL clear_exec: state %0d res %b done %b want 0 000000 0", state_o, result_q, done); end
        @(negedge clk);
        total++; if (done !== 1'b0 || result_q !== 6'b0 || state_o !== 3'd0) begin bad++; $display("[TB] FAIL clear_exec_after: done %b res %b state %0d want 0 000000 0", done, result_q, state_o); end
    endtask

    task automatic test_show_reload();
        pulse_load(6'b111000, 4'h0);
        pulse_load(6'b010000, 4'h0);
        pulse_load(6'b000000, 4'h0);
        @(negedge clk);
        total++; if (result_q !== 6'b001000 || flag_c !== 1'b1 || flag_n !== 1'b0) begin bad++; $display("[TB] FAIL add_carry: res %b c %b n %b want 001000 1 0", result_q, flag_c, flag_n); end
        pulse_load(6'b000111, 4'h0);
        total++; if (op_a !== 6'b000111 || state_o !== 3'd1) begin bad++; $display("[TB] FAIL show_reload: a %b state %0d want 000111 1", op_a, state_o); end
        total++; if (result_q !== 6'b001000 || op_b !== 6'b010000 || flag_c !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL show_keep: res %b b %b c %b done %b want 001000 010000 1 0", result_q, op_b, flag_c, done); end
    endtask

    task automatic test_reset_mid_exec();
        pulse_load(6'b000010, 4'h0);
        pulse_load(6'b000000, 4'h0);
        total++; if (state_o !== 3'd3) begin bad++; $display("[TB] FAIL reach_exec: got %0d want 3", state_o); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (state_o !== 3'd0 || {op_a, op_b, alu_op, result_q} !== '0) begin bad++; $display("[TB] FAIL async_reset_regs: state %0d a %b b %b op %h res %b want all 0", state_o, op_a, op_b, alu_op, result_q); end
        total++; if ({flag_z, flag_n, flag_c, done} !== 4'b1000) begin bad++; $display("[TB] FAIL async_reset_flags: got %b want 1000", {flag_z, flag_n, flag_c, done}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (state_o !== 3'd0 || done !== 1'b0) begin bad++; $display("[TB] FAIL resume_load_a: state %0d done %b want 0 0", state_o, done); end
    endtask

    initial begin
        test_reset();
        test_xor();
        test_zero();
        test_load_in_exec();
        test_clear_load_op();
        test_clear_exec();
        test_show_reload();
        test_reset_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Sequential front end of the Lab 3 ALU. Loads operand A, operand B and a 4-bit opcode from board switches on successive load-button pulses.
- Presents all three as stable registered signals to the combinational ALU, which includes the N-bit logic operator arrays.
- Registers the ALU result one cycle later and derives the Z/N/C status flags for the display and LED stage.

Parameters:
- N, 6, operand and result width in bits (N >= 2).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- load  input  1  single-cycle pulse, already debounced and edge-detected upstream
- clear  input  1  synchronous abort to LOAD_A, sampled every cycle
- sw_data  input  N  switch value captured as operand A or B
- sw_op  input  4  switch value captured as the opcode
- alu_result  input  N  combinational ALU output
- alu_cout  input  1  ALU carry/borrow out
- op_a  output  N  registered operand A to the ALU
- op_b  output  N  registered operand B to the ALU
- alu_op  output  4  registered opcode to the ALU
- result_q  output  N  registered ALU result
- flag_z  output  1  result_q == 0
- flag_n  output  1  result_q[N-1]
- flag_c  output  1  registered alu_cout
- done  output  1  one-cycle pulse when result_q updates
- state_o  output  3  current state encoding, for LEDs

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to LOAD_A.
  - op_a, op_b, alu_op, result_q, flag_c and done are all 0.
  - flag_z = 1, because it is derived from result_q = 0.
  - flag_n = 0.
- State encodings: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4. Codes 5–7 are illegal and go to LOAD_A on the next edge.
- LOAD_A: on load, op_a <= sw_data and state goes to LOAD_B.
- LOAD_B: on load, op_b <= sw_data and state goes to LOAD_OP.
- LOAD_OP: on load, alu_op <= sw_op and state goes to EXEC.
- EXEC:
  - Lasts exactly one cycle. The ALU inputs are stable throughout it.
  - At the closing edge: result_q <= alu_result, flag_c <= alu_cout, state goes to SHOW.
  - load during EXEC is ignored.
- SHOW:
  - done = 1 during the first SHOW cycle only. It is registered, set on the EXEC→SHOW edge.
  - Outputs hold until load arrives.
  - load: op_a <= sw_data and state goes to LOAD_B. This starts a new operation without an extra press.
  - op_b, alu_op and result_q keep their old values until overwritten.
- Latency: 2 rising edges from the load pulse that captures the opcode to the update of result_q and flags (the capture edge and the EXEC edge).
- flag_z and flag_n are combinational from result_q, so they change on the same edge as result_q.
- clear:
  - Has priority over load in every state.
  - Next state is LOAD_A.
  - op_a, op_b, alu_op, result_q and flag_c go to 0; done goes to 0.
  - clear during EXEC cancels the capture: result_q stays at 0 and done never pulses.
- load held high for several cycles: each high cycle counts as a separate press. This is an upstream contract; the block does not filter it.
- Operands are captured as-is. There is no width extension or sign handling; the ALU interprets them.
- Reset asserted mid-operation aborts immediately. On release, the block resumes in LOAD_A.

Test Plan:
- Reset, then release -> state_o=0, all outputs 0 except flag_z=1, done=0.
- Load 6'b101100, load 6'b011010, load XOR opcode, with a bench ALU model -> result_q=6'b110110 exactly 2 edges after the opcode load; flag_n=1, flag_z=0, done high for one cycle.
- A=B=6'b010101 with XOR -> result_q=0, flag_z=1, flag_n=0.
- Pulse load during EXEC -> ignored; state goes to SHOW and op_b is unchanged.
- clear in LOAD_OP, and separately in EXEC -> state_o=0, result_q=0, no done pulse.
- From SHOW, load 6'b000111 -> op_a=6'b000111, state_o=1, result_q keeps its previous value. Also assert rst_n low mid-EXEC -> outputs go to reset values immediately, without waiting for a clock edge.
